// File: rtl/bounce_gen_pkg.sv
// Shared definitions for the contact-bounce emulator: FSM encoding and
// LFSR constants used by bounce_gen and its lfsr16 sub-block.
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam int unsigned LFSR_W       = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  // Right-shifting Galois step; a nonzero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    lfsr_next = {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// 16-bit Galois LFSR, free-running every cycle, loaded with seed on reset.
module lfsr16
  import bounce_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= seed;
    end else begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign q = state_q;

endmodule

// File: rtl/bounce_gen.sv
// Emulates a bouncing mechanical contact: on a level request, toggles the
// output NUM_BOUNCES extra times at pseudo-random gaps, then holds stable.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int unsigned       NUM_BOUNCES = 6,
  parameter int unsigned       GAP_MIN     = 1000,
  parameter int unsigned       GAP_BITS    = 10,
  parameter int unsigned       HOLD_CYCLES = 1100000,
  parameter logic [LFSR_W-1:0] SEED        = DEFAULT_SEED
)(
  input  logic clk,
  input  logic rst,
  input  logic cmd_level,
  output logic bouncy,
  output logic busy,
  output logic done
);

  localparam int unsigned GAP_W  = 21;
  localparam int unsigned TOG_W  = 8;
  localparam int unsigned HOLD_W = 21;
  localparam logic [LFSR_W-1:0] GAP_MASK = LFSR_W'((32'd1 << GAP_BITS) - 32'd1);

  if (NUM_BOUNCES > 254 || (NUM_BOUNCES % 2) != 0) begin : g_chk_nb
    $error("bounce_gen: NUM_BOUNCES must be even and <= 254");
  end
  if (GAP_MIN < 1 || GAP_MIN > 32'h000F_FFFF) begin : g_chk_gmin
    $error("bounce_gen: GAP_MIN must be in 1..2^20-1");
  end
  if (GAP_BITS > 12) begin : g_chk_gbits
    $error("bounce_gen: GAP_BITS must be in 0..12");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 32'h001F_FFFF) begin : g_chk_hold
    $error("bounce_gen: HOLD_CYCLES must be in 1..2^21-1");
  end
  if (SEED == '0) begin : g_chk_seed
    $error("bounce_gen: SEED must be nonzero");
  end

  logic [LFSR_W-1:0] lfsr_q;
  logic [GAP_W-1:0]  gap_load;

  state_e            state_q;
  logic              level_q;
  logic              bouncy_q;
  logic              busy_q;
  logic              done_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [TOG_W-1:0]  toggles_left_q;
  logic [HOLD_W-1:0] hold_cnt_q;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Masking instead of slicing keeps GAP_BITS == 0 legal (deterministic gaps).
  assign gap_load = GAP_W'(GAP_MIN) + GAP_W'(lfsr_q & GAP_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      level_q        <= 1'b0;
      bouncy_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      gap_cnt_q      <= '0;
      toggles_left_q <= '0;
      hold_cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (cmd_level != level_q) begin
            bouncy_q       <= ~level_q;
            gap_cnt_q      <= gap_load;
            toggles_left_q <= TOG_W'(NUM_BOUNCES);
            busy_q         <= 1'b1;
            state_q        <= ST_BOUNCE;
          end
        end
        ST_BOUNCE: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end else if (toggles_left_q != '0) begin
            bouncy_q       <= ~bouncy_q;
            toggles_left_q <= toggles_left_q - 1'b1;
            gap_cnt_q      <= gap_load;
          end else begin
            hold_cnt_q <= HOLD_W'(HOLD_CYCLES - 1);
            state_q    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end else begin
            level_q <= bouncy_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bouncy = bouncy_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: a deterministic-gap instance for exact
// waveform checks and a small randomised instance checked against an LFSR model.
module tb_bounce_gen;

  localparam int unsigned NB1 = 4,  GM1 = 3, GB1 = 0, HC1 = 10;
  localparam int unsigned NB2 = 6,  GM2 = 5, GB2 = 3, HC2 = 4;
  localparam logic [15:0] SEED_TB = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  logic cmd1, cmd2;
  logic bouncy1, busy1, done1;
  logic bouncy2, busy2, done2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr, m_prev;

  always #5 clk = ~clk;

  bounce_gen #(
    .NUM_BOUNCES (NB1),
    .GAP_MIN     (GM1),
    .GAP_BITS    (GB1),
    .HOLD_CYCLES (HC1),
    .SEED        (SEED_TB)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .cmd_level (cmd1),
    .bouncy    (bouncy1),
    .busy      (busy1),
    .done      (done1)
  );

  bounce_gen #(
    .NUM_BOUNCES (NB2),
    .GAP_MIN     (GM2),
    .GAP_BITS    (GB2),
    .HOLD_CYCLES (HC2),
    .SEED        (SEED_TB)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .cmd_level (cmd2),
    .bouncy    (bouncy2),
    .busy      (busy2),
    .done      (done2)
  );

  // Reference LFSR; m_prev is the value the DUT saw just before the last edge.
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (rst) m_lfsr <= SEED_TB;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bouncy for the GAP=3, 4-bounce config, k edges after the request.
  function automatic logic exp_b(input int k, input logic target);
    if (k >= 16) return target;
    return ((k / 4) % 2 == 0) ? target : ~target;
  endfunction

  task automatic test_reset();
    rst = 1'b1; cmd1 = 1'b0; cmd2 = 1'b0;
    tick(); tick();
    n_checks++; if (bouncy1 !== 1'b0) begin n_fail++; $display("FAIL reset_bouncy1 got %b want 0", bouncy1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1 got %b want 0", done1); end
    n_checks++; if (bouncy2 !== 1'b0) begin n_fail++; $display("FAIL reset_bouncy2 got %b want 0", bouncy2); end
    n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy2 got %b want 0", busy2); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (busy1 !== 1'b0 || bouncy1 !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%b bouncy=%b want 0/0", busy1, bouncy1); end
    end
  endtask

  task automatic test_rise();
    cmd1 = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      tick();
      n_checks++; if (bouncy1 !== exp_b(k, 1'b1)) begin n_fail++; $display("FAIL rise_bouncy k=%0d got %b want %b", k, bouncy1, exp_b(k, 1'b1)); end
      n_checks++; if (busy1 !== (k < 30)) begin n_fail++; $display("FAIL rise_busy k=%0d got %b want %b", k, busy1, (k < 30)); end
      n_checks++; if (done1 !== (k == 30)) begin n_fail++; $display("FAIL rise_done k=%0d got %b want %b", k, done1, (k == 30)); end
    end
  endtask

  task automatic test_fall();
    cmd1 = 1'b0;
    for (int k = 0; k <= 33; k++) begin
      tick();
      n_checks++; if (bouncy1 !== exp_b(k, 1'b0)) begin n_fail++; $display("FAIL fall_bouncy k=%0d got %b want %b", k, bouncy1, exp_b(k, 1'b0)); end
      n_checks++; if (busy1 !== (k < 30)) begin n_fail++; $display("FAIL fall_busy k=%0d got %b want %b", k, busy1, (k < 30)); end
      n_checks++; if (done1 !== (k == 30)) begin n_fail++; $display("FAIL fall_done k=%0d got %b want %b", k, done1, (k == 30)); end
    end
  endtask

  // cmd chatters mid-sequence and ends opposite to the target, so a second
  // sequence must start on the edge right after done.
  task automatic test_ignore_cmd();
    logic tgt;
    int   kk;
    cmd1 = 1'b1;
    for (int k = 0; k <= 63; k++) begin
      tick();
      tgt = (k < 31) ? 1'b1 : 1'b0;
      kk  = (k < 31) ? k : k - 31;
      n_checks++; if (bouncy1 !== exp_b(kk, tgt)) begin n_fail++; $display("FAIL ignore_bouncy k=%0d got %b want %b", k, bouncy1, exp_b(kk, tgt)); end
      n_checks++; if (busy1 !== (kk < 30)) begin n_fail++; $display("FAIL ignore_busy k=%0d got %b want %b", k, busy1, (kk < 30)); end
      n_checks++; if (done1 !== (kk == 30)) begin n_fail++; $display("FAIL ignore_done k=%0d got %b want %b", k, done1, (kk == 30)); end
      if (k < 29) cmd1 = ~cmd1;
      else        cmd1 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    cmd1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++; if (bouncy1 !== exp_b(k, 1'b1)) begin n_fail++; $display("FAIL mid_pre_bouncy k=%0d got %b want %b", k, bouncy1, exp_b(k, 1'b1)); end
    end
    rst = 1'b1;
    tick();
    n_checks++; if (bouncy1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_bouncy got %b want 0", bouncy1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done got %b want 0", done1); end
    tick();
    rst = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      tick();
      n_checks++; if (bouncy1 !== exp_b(k, 1'b1)) begin n_fail++; $display("FAIL restart_bouncy k=%0d got %b want %b", k, bouncy1, exp_b(k, 1'b1)); end
      n_checks++; if (busy1 !== (k < 30)) begin n_fail++; $display("FAIL restart_busy k=%0d got %b want %b", k, busy1, (k < 30)); end
      n_checks++; if (done1 !== (k == 30)) begin n_fail++; $display("FAIL restart_done k=%0d got %b want %b", k, done1, (k == 30)); end
    end
  endtask

  task automatic test_random_gaps();
    logic lvl, tgt, prevb, got_done;
    int   edges, cyc, last_edge, exp_gap, wait_n;
    lvl = 1'b0;
    for (int s = 0; s < 25; s++) begin
      wait_n = $urandom_range(0, 3);
      cmd2   = lvl;
      for (int w = 0; w < wait_n; w++) begin
        tick();
        n_checks++; if (busy2 !== 1'b0 || bouncy2 !== lvl) begin n_fail++; $display("FAIL rnd_idle s=%0d busy=%b bouncy=%b want 0/%b", s, busy2, bouncy2, lvl); end
      end
      tgt = ~lvl; cmd2 = tgt;
      edges = 0; cyc = 0; last_edge = 0; exp_gap = 0; prevb = lvl; got_done = 1'b0;
      while (!got_done && cyc < 400) begin
        tick();
        cyc++;
        if (bouncy2 !== prevb) begin
          edges++;
          if (edges == 1) begin
            n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL rnd_first_edge s=%0d got cycle %0d want 1", s, cyc); end
          end else begin
            n_checks++; if (cyc - last_edge != exp_gap) begin n_fail++; $display("FAIL rnd_gap s=%0d edge=%0d got %0d want %0d", s, edges, cyc - last_edge, exp_gap); end
            n_checks++; if (cyc - last_edge < 6 || cyc - last_edge > 13) begin n_fail++; $display("FAIL rnd_gap_range s=%0d got %0d want 6..13", s, cyc - last_edge); end
          end
          exp_gap   = int'(GM2) + int'(m_prev & 16'h0007) + 1;
          last_edge = cyc;
          prevb     = bouncy2;
        end
        if (done2 === 1'b1) begin
          got_done = 1'b1;
          n_checks++; if (edges != 7) begin n_fail++; $display("FAIL rnd_edge_count s=%0d got %0d want 7", s, edges); end
          n_checks++; if (bouncy2 !== tgt) begin n_fail++; $display("FAIL rnd_final_level s=%0d got %b want %b", s, bouncy2, tgt); end
          n_checks++; if (cyc != last_edge + exp_gap + int'(HC2)) begin n_fail++; $display("FAIL rnd_done_time s=%0d got %0d want %0d", s, cyc, last_edge + exp_gap + int'(HC2)); end
          n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL rnd_busy_end s=%0d got %b want 0", s, busy2); end
        end else begin
          n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL rnd_busy s=%0d cyc=%0d got %b want 1", s, cyc, busy2); end
        end
      end
      if (!got_done) begin
        n_checks++; n_fail++;
        $display("FAIL rnd_timeout s=%0d no done within 400 cycles, edges=%0d", s, edges);
      end
      lvl = tgt;
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_ignore_cmd();
    test_reset_mid();
    test_random_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter NUM_BOUNCES, default 6, meaning extra toggles after the first edge; it must be even and at most 254.
REQ-002 SHALL have parameter GAP_MIN, default 1000, meaning the minimum reload value G of the inter-toggle counter, 1..2^20-1.
REQ-003 SHALL have parameter GAP_BITS, default 10, meaning the LFSR bits added to GAP_MIN (0..12); 0 gives deterministic gaps.
REQ-004 SHALL have parameter HOLD_CYCLES, default 1100000, meaning stable cycles after the final edge, 1..2^21-1.
REQ-005 SHALL have parameter SEED, default 16'hACE1, meaning the nonzero LFSR reset value.
REQ-006 SHALL reject out-of-range parameter values at elaboration.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 cmd_level  input  1  clean requested switch level.
REQ-010 bouncy  output  1  emulated contact-bounce waveform, registered.
REQ-011 busy  output  1  high while a bounce/hold sequence is in progress, registered.
REQ-012 done  output  1  one-cycle pulse when a sequence completes, registered.

Function
REQ-013 SHALL implement states IDLE, BOUNCE and HOLD, plus internal registers level_q, gap_cnt, toggles_left and hold_cnt.
REQ-014 In IDLE with cmd_level == level_q, outputs hold: bouncy=level_q, busy=0, done=0.
REQ-015 In IDLE with cmd_level != level_q, on the next edge: bouncy<=~level_q, gap_cnt<=G, toggles_left<=NUM_BOUNCES, busy<=1, state<=BOUNCE.
REQ-016 G SHALL equal GAP_MIN + lfsr[GAP_BITS-1:0], sampled at each load; add zero-extended; no overflow is allowed by the range limits.
REQ-017 In BOUNCE with gap_cnt != 0, gap_cnt decrements each cycle.
REQ-018 In BOUNCE with gap_cnt == 0 and toggles_left != 0: bouncy toggles, toggles_left decrements and gap_cnt reloads with a fresh G; consecutive edges are therefore G+1 cycles apart.
REQ-019 In BOUNCE with gap_cnt == 0 and toggles_left == 0: hold_cnt<=HOLD_CYCLES-1, state<=HOLD, bouncy unchanged (equals the target level).
REQ-020 In HOLD, hold_cnt decrements to 0; at 0: state<=IDLE, level_q<=bouncy, busy<=0, done<=1 for exactly one cycle.
REQ-021 cmd_level SHALL be sampled only in IDLE; changes during BOUNCE/HOLD are ignored.
REQ-022 A mismatch still present on return to IDLE starts a new sequence on the following edge.
REQ-023 A request and the final edge of a sequence SHALL never coincide; the IDLE cycle between sequences is mandatory.
REQ-024 The LFSR SHALL be a 16-bit Galois LFSR with taps 16'hB400, advancing every cycle in all states, never reaching zero.

Reset
REQ-025 rst SHALL set state=IDLE, bouncy=0, level_q=0, busy=0, done=0, counters=0, lfsr=SEED on the next edge.
REQ-026 rst SHALL take priority over all other logic, including mid-sequence, where the sequence is aborted with no done pulse.

Structure
REQ-027 The shared package SHALL hold the state encoding, LFSR width, tap constant 16'hB400 and the default SEED.
REQ-028 The LFSR SHALL be the sub-module lfsr16 (ports clk, rst, seed, q), instantiated once.

Verification
REQ-029 Scenario 1: NUM_BOUNCES=4, GAP_MIN=3, GAP_BITS=0, HOLD_CYCLES=10; cmd_level 0->1 sampled at edge E0 -> bouncy edges at E0, E4, E8, E12, E16 (final 1); done high after E30 for one cycle; busy high E0..E30.
REQ-030 Scenario 2: same config, then cmd_level 1->0 -> mirrored sequence ending bouncy=0, level_q=0.
REQ-031 Scenario 3: toggle cmd_level repeatedly during BOUNCE -> waveform unchanged; a new sequence starts one cycle after done only if cmd_level != level_q.
REQ-032 Scenario 4: assert rst at E10 of Scenario 1 -> next edge bouncy=0, busy=0, no done pulse; after release with cmd_level=1, a fresh sequence starts.
REQ-033 Scenario 5: defaults, 1000 random requests -> every gap between edges lies in 1001..2024 cycles, edge count per sequence is 7, and final level equals the request.
REQ-034 Scenario 6: bouncy looped into the team debouncer with HOLD_CYCLES above its threshold -> the debouncer output changes exactly once per sequence and matches cmd_level.
